mem_store_buffer: RTL and testbench

- Write buffer between the MEM-stage load/store path and Data_Memory.
- Queues up to DEPTH stores and drains them one per cycle into the memory's MemWrite port whenever that port is free.
- Forwards buffered data to loads that hit a pending entry; load misses go straight to memory.
- A fence request drains the buffer completely before more stores are accepted.

---
 rtl/mem_store_buffer.sv | 151 +++++++++++++++
 tb/tb_mem_store_buffer.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_store_buffer.sv
// Store buffer between the MEM-stage load/store path and Data_Memory: queues stores,
// forwards to hitting loads, drains on idle port cycles. Optional: STORE_COALESCE_EN.
module mem_store_buffer #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   st_valid,
    input  logic [ADDR_W-1:0]      st_addr,
    input  logic [DATA_W-1:0]      st_data,
    output logic                   st_ready,
    input  logic                   ld_valid,
    input  logic [ADDR_W-1:0]      ld_addr,
    output logic [DATA_W-1:0]      ld_data,
    output logic                   ld_hit,
    input  logic                   fence_req,
    output logic                   fence_done,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count,
    output logic                   mem_read,
    output logic                   mem_write,
    output logic [ADDR_W-1:0]      mem_addr,
    output logic [DATA_W-1:0]      mem_wdata,
    input  logic [DATA_W-1:0]      mem_rdata
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    localparam logic [0:0] ST_RUN   = 1'b0;
    localparam logic [0:0] ST_FLUSH = 1'b1;

    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [PTR_W-1:0]  head_q;
    logic [PTR_W-1:0]  tail_q;
    logic [CNT_W-1:0]  count_q;
    logic [CNT_W-1:0]  count_next;
    logic [0:0]        state_q;
    logic              fence_done_q;

    logic              ld_match;
    logic [PTR_W-1:0]  ld_idx;
    logic [PTR_W-1:0]  ld_scan;
    logic              load_miss;
    logic              drain;
    logic              coal_hit;
    logic [PTR_W-1:0]  coal_idx;
    logic              accept;
    logic              alloc;

    // Scan oldest to youngest so the last match is the youngest pending store.
    always_comb begin
        ld_match = 1'b0;
        ld_idx   = '0;
        ld_scan  = '0;
        for (int a = 0; a < DEPTH; a++) begin
            ld_scan = head_q + PTR_W'(a);
            if ((CNT_W'(a) < count_q) && (addr_q[ld_scan] == ld_addr)) begin
                ld_match = 1'b1;
                ld_idx   = ld_scan;
            end
        end
    end

    assign load_miss = ld_valid && !ld_match;
    assign ld_hit    = ld_valid && ld_match;
    assign ld_data   = !ld_valid ? '0 : (ld_match ? data_q[ld_idx] : mem_rdata);

    // Drain is held off during reset so discarded stores never reach memory.
    assign drain     = !rst && !load_miss && (count_q != '0);
    assign mem_read  = load_miss;
    assign mem_write = drain;
    assign mem_addr  = load_miss ? ld_addr : (drain ? addr_q[head_q] : '0);
    assign mem_wdata = drain ? data_q[head_q] : '0;

`ifdef STORE_COALESCE_EN
    logic [PTR_W-1:0] st_scan;

    // The head entry is off limits while it is leaving the buffer this cycle.
    always_comb begin
        coal_hit = 1'b0;
        coal_idx = '0;
        st_scan  = '0;
        for (int a = 0; a < DEPTH; a++) begin
            st_scan = head_q + PTR_W'(a);
            if ((CNT_W'(a) < count_q) && (addr_q[st_scan] == st_addr) &&
                !(drain && (a == 0))) begin
                coal_hit = 1'b1;
                coal_idx = st_scan;
            end
        end
    end
`else
    assign coal_hit = 1'b0;
    assign coal_idx = '0;
`endif

    assign st_ready = (state_q == ST_RUN) && ((count_q < FULL_CNT) || drain || coal_hit);
    assign accept   = st_valid && st_ready;
    assign alloc    = accept && !coal_hit;

    assign count_next = count_q + {{PTR_W{1'b0}}, alloc} - {{PTR_W{1'b0}}, drain};

    assign count      = count_q;
    assign empty      = (count_q == '0);
    assign fence_done = fence_done_q;

    // NOTE: all state updates use non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q       <= '0;
            tail_q       <= '0;
            count_q      <= '0;
            state_q      <= ST_RUN;
            fence_done_q <= 1'b0;
        end else begin
            count_q      <= count_next;
            fence_done_q <= 1'b0;
            if (drain) head_q <= head_q + PTR_W'(1);
            if (alloc) tail_q <= tail_q + PTR_W'(1);
            case (state_q)
                ST_RUN: begin
                    if (fence_req) begin
                        if (count_next == '0) fence_done_q <= 1'b1;
                        else                  state_q      <= ST_FLUSH;
                    end
                end
                ST_FLUSH: begin
                    if (count_next == '0) begin
                        state_q      <= ST_RUN;
                        fence_done_q <= 1'b1;
                    end
                end
            endcase
        end
    end

    // NOTE: entry storage has no reset; validity comes solely from head/count.
    always_ff @(posedge clk) begin
        if (alloc) begin
            addr_q[tail_q] <= st_addr;
            data_q[tail_q] <= st_data;
        end else if (accept) begin
            data_q[coal_idx] <= st_data;
        end
    end

endmodule

// File: tb/tb_mem_store_buffer.sv
// Directed self-checking bench for mem_store_buffer: drain, fill/backpressure,
// forwarding, load miss, fences and mid-operation reset.
module tb_mem_store_buffer;
    localparam int DEPTH  = 4;
    localparam int ADDR_W = 16;
    localparam int DATA_W = 16;

`ifdef STORE_COALESCE_EN
    localparam int EXP_FWD_CNT  = 1;
    localparam int EXP_FWD_HEAD = 32'h0022;
`else
    localparam int EXP_FWD_CNT  = 2;
    localparam int EXP_FWD_HEAD = 32'h0011;
`endif

    logic                   clk;
    logic                   rst;
    logic                   st_valid;
    logic [ADDR_W-1:0]      st_addr;
    logic [DATA_W-1:0]      st_data;
    logic                   st_ready;
    logic                   ld_valid;
    logic [ADDR_W-1:0]      ld_addr;
    logic [DATA_W-1:0]      ld_data;
    logic                   ld_hit;
    logic                   fence_req;
    logic                   fence_done;
    logic                   empty;
    logic [$clog2(DEPTH):0] count;
    logic                   mem_read;
    logic                   mem_write;
    logic [ADDR_W-1:0]      mem_addr;
    logic [DATA_W-1:0]      mem_wdata;
    logic [DATA_W-1:0]      mem_rdata;

    int checks     = 0;
    int errors     = 0;
    int bad_writes = 0;

    logic [15:0] drain_addr [4] = '{16'd2, 16'd3, 16'd4, 16'd9};
    logic [15:0] drain_data [4] = '{16'h0102, 16'h0103, 16'h0104, 16'hBEEF};

    mem_store_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .st_valid   (st_valid),
        .st_addr    (st_addr),
        .st_data    (st_data),
        .st_ready   (st_ready),
        .ld_valid   (ld_valid),
        .ld_addr    (ld_addr),
        .ld_data    (ld_data),
        .ld_hit     (ld_hit),
        .fence_req  (fence_req),
        .fence_done (fence_done),
        .empty      (empty),
        .count      (count),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Any memory write of the stores discarded by the mid-operation reset is an error.
    always @(posedge clk) begin
        if (mem_write && (mem_addr >= 16'd50) && (mem_addr <= 16'd52)) bad_writes++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; st_valid = 1'b0; st_addr = '0; st_data = '0;
        ld_valid = 1'b0; ld_addr = '0; fence_req = 1'b0; mem_rdata = '0;
        repeat (2) @(posedge clk);
        #1;

        // Reset state
        @(negedge clk);
        check("rst_st_ready",   32'(st_ready),   32'd1);
        check("rst_empty",      32'(empty),      32'd1);
        check("rst_count",      32'(count),      32'd0);
        check("rst_ld_hit",     32'(ld_hit),     32'd0);
        check("rst_ld_data",    32'(ld_data),    32'd0);
        check("rst_mem_read",   32'(mem_read),   32'd0);
        check("rst_mem_write",  32'(mem_write),  32'd0);
        check("rst_fence_done", 32'(fence_done), 32'd0);
        next_cycle();
        rst = 1'b0;

        // Single store: written to memory one cycle after acceptance
        st_valid = 1'b1; st_addr = 16'd5; st_data = 16'h1234;
        @(negedge clk);
        check("t1_st_ready",   32'(st_ready),  32'd1);
        check("t1_empty_nowr", 32'(mem_write), 32'd0);
        next_cycle();
        st_valid = 1'b0;
        @(negedge clk);
        check("t1_mem_write", 32'(mem_write), 32'd1);
        check("t1_mem_addr",  32'(mem_addr),  32'd5);
        check("t1_mem_wdata", 32'(mem_wdata), 32'h1234);
        check("t1_count",     32'(count),     32'd1);
        next_cycle();
        @(negedge clk);
        check("t1_count0",    32'(count),     32'd0);
        check("t1_empty",     32'(empty),     32'd1);
        check("t1_nowrite",   32'(mem_write), 32'd0);
        next_cycle();

        // Fill while a load miss blocks the drain; entries wrap past DEPTH-1
        ld_valid = 1'b1; ld_addr = 16'd40;
        for (int i = 1; i <= 4; i++) begin
            st_valid = 1'b1; st_addr = 16'(i); st_data = 16'(16'h0100 + i);
            @(negedge clk);
            check("fill_st_ready", 32'(st_ready),  32'd1);
            check("fill_nowrite",  32'(mem_write), 32'd0);
            next_cycle();
        end
        st_addr = 16'd9; st_data = 16'hBEEF;
        @(negedge clk);
        check("full_count",    32'(count),    32'd4);
        check("full_st_ready", 32'(st_ready), 32'd0);
        check("full_mem_read", 32'(mem_read), 32'd1);
        next_cycle();
        ld_valid = 1'b0;
        @(negedge clk);
        check("full_drain_ready", 32'(st_ready),  32'd1);
        check("drain0_write",     32'(mem_write), 32'd1);
        check("drain0_addr",      32'(mem_addr),  32'd1);
        check("drain0_data",      32'(mem_wdata), 32'h0101);
        check("drain0_count",     32'(count),     32'd4);
        next_cycle();
        st_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("drain_addr",  32'(mem_addr),  32'(drain_addr[k]));
            check("drain_data",  32'(mem_wdata), 32'(drain_data[k]));
            check("drain_count", 32'(count),     32'(4 - k));
            next_cycle();
        end
        @(negedge clk);
        check("drain_empty",   32'(empty),     32'd1);
        check("drain_nowrite", 32'(mem_write), 32'd0);
        next_cycle();

        // Forwarding from the youngest of two stores to one address
        ld_valid = 1'b1; ld_addr = 16'd40;
        st_valid = 1'b1; st_addr = 16'd17; st_data = 16'h0011;
        @(negedge clk);
        check("fwd_st0_ready", 32'(st_ready), 32'd1);
        next_cycle();
        st_data = 16'h0022;
        @(negedge clk);
        check("fwd_st1_ready", 32'(st_ready),  32'd1);
        check("fwd_st1_nowr",  32'(mem_write), 32'd0);
        next_cycle();
        st_valid = 1'b0; ld_addr = 16'd17;
        @(negedge clk);
        check("fwd_ld_hit",    32'(ld_hit),    32'd1);
        check("fwd_ld_data",   32'(ld_data),   32'h0022);
        check("fwd_mem_read",  32'(mem_read),  32'd0);
        check("fwd_count",     32'(count),     32'(EXP_FWD_CNT));
        check("fwd_head_data", 32'(mem_wdata), 32'(EXP_FWD_HEAD));
        next_cycle();
        ld_valid = 1'b0;
        for (int n = 0; n < 8 && count != '0; n++) next_cycle();
        @(negedge clk);
        check("fwd_drained", 32'(empty), 32'd1);
        next_cycle();

        // Load miss reads memory
        ld_valid = 1'b1; ld_addr = 16'd15; mem_rdata = 16'd65;
        @(negedge clk);
        check("miss_ld_hit",    32'(ld_hit),    32'd0);
        check("miss_mem_read",  32'(mem_read),  32'd1);
        check("miss_mem_write", 32'(mem_write), 32'd0);
        check("miss_ld_data",   32'(ld_data),   32'd65);
        check("miss_mem_addr",  32'(mem_addr),  32'd15);
        next_cycle();
        ld_valid = 1'b0;
        @(negedge clk);
        check("noload_ld_data",  32'(ld_data),  32'd0);
        check("noload_mem_read", 32'(mem_read), 32'd0);
        next_cycle();

        // Fence on an empty buffer completes immediately
        fence_req = 1'b1;
        @(negedge clk);
        check("efence_done0", 32'(fence_done), 32'd0);
        next_cycle();
        fence_req = 1'b0;
        @(negedge clk);
        check("efence_done1", 32'(fence_done), 32'd1);
        check("efence_ready", 32'(st_ready),   32'd1);
        next_cycle();
        @(negedge clk);
        check("efence_done2", 32'(fence_done), 32'd0);
        next_cycle();

        // Fence with three entries; a store held during the flush
        ld_valid = 1'b1; ld_addr = 16'd40;
        for (int i = 0; i < 3; i++) begin
            st_valid = 1'b1; st_addr = 16'(20 + i); st_data = 16'(16'h0200 + i);
            next_cycle();
        end
        st_valid = 1'b0; fence_req = 1'b1;
        @(negedge clk);
        check("fence_count3",   32'(count),     32'd3);
        check("fence_req_rdy",  32'(st_ready),  32'd1);
        check("fence_req_nowr", 32'(mem_write), 32'd0);
        next_cycle();
        fence_req = 1'b0; ld_valid = 1'b0;
        st_valid = 1'b1; st_addr = 16'd30; st_data = 16'h0300;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("flush_st_ready", 32'(st_ready),   32'd0);
            check("flush_addr",     32'(mem_addr),   32'(20 + i));
            check("flush_count",    32'(count),      32'(3 - i));
            check("flush_nodone",   32'(fence_done), 32'd0);
            next_cycle();
        end
        @(negedge clk);
        check("fence_done",       32'(fence_done), 32'd1);
        check("fence_done_count", 32'(count),      32'd0);
        check("fence_done_ready", 32'(st_ready),   32'd1);
        next_cycle();
        st_valid = 1'b0;
        @(negedge clk);
        check("fence_done_once", 32'(fence_done), 32'd0);
        check("post_fence_wr",   32'(mem_write),  32'd1);
        check("post_fence_addr", 32'(mem_addr),   32'd30);
        check("post_fence_data", 32'(mem_wdata),  32'h0300);
        next_cycle();

        // Mid-operation reset discards buffered stores without writing memory
        ld_valid = 1'b1; ld_addr = 16'd40;
        for (int i = 0; i < 3; i++) begin
            st_valid = 1'b1; st_addr = 16'(50 + i); st_data = 16'(16'h0500 + i);
            next_cycle();
        end
        st_valid = 1'b0; ld_valid = 1'b0; rst = 1'b1;
        @(negedge clk);
        check("mrst_pre_count", 32'(count),     32'd3);
        check("mrst_pre_nowr",  32'(mem_write), 32'd0);
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        check("mrst_count",      32'(count),      32'd0);
        check("mrst_empty",      32'(empty),      32'd1);
        check("mrst_nowrite",    32'(mem_write),  32'd0);
        check("mrst_fence_done", 32'(fence_done), 32'd0);
        next_cycle();
        next_cycle();
        check("mrst_no_mem_write", 32'(bad_writes), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "bench timeout");
    end

endmodule
